// File: rtl/pixel_scanout.sv
// Framebuffered VGA scanout: 160x120x9 pixel store written by a plot port,
// read in raster order and shown as 4x4 blocks on a 640x480@60 Hz timing.
module pixel_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] iX,
  input  logic [6:0] iY,
  input  logic [8:0] iColour,
  input  logic       iPlot,
  output logic [7:0] oVGA_R,
  output logic [7:0] oVGA_G,
  output logic [7:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_N,
  output logic       oVGA_SYNC_N,
  output logic       oVGA_CLK,
  output logic       oFrameStart,
  output logic       oWriteDropped
);

  localparam int FB_DEPTH = 19200;

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  logic        pix_en;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [8:0]  fb [0:FB_DEPTH-1];
  logic [8:0]  rd_data;
  logic        wr_ok;
  logic        visible;
  logic        hs_s;
  logic        vs_s;
  logic        at_wrap;
  logic [14:0] wr_addr;
  logic [14:0] rd_addr;

  // Address generation and timing decode from the current counter values.
  always_comb begin
    wr_ok   = 1'b0;
    wr_addr = 15'd0;
    rd_addr = 15'd0;
    visible = 1'b0;
    hs_s    = 1'b1;
    vs_s    = 1'b1;
    at_wrap = 1'b0;
    wr_ok   = iPlot && (iX < 8'd160) && (iY < 7'd120);
    wr_addr = {1'b0, iY, 7'b0} + {3'b0, iY, 5'b0} + {7'b0, iX};
    rd_addr = {1'b0, v_cnt[8:2], 7'b0} + {3'b0, v_cnt[8:2], 5'b0} + {7'b0, h_cnt[9:2]};
    visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_s    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_s    = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    at_wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  end

  // Framebuffer write port; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      fb[wr_addr] <= iColour;
    end
  end

  // Read every clock while visible: the off-phase read feeds the next pix_en tick,
  // and a same-edge write is not seen until the following read.
  always_ff @(posedge clock) begin
    if (visible) begin
      rd_data <= fb[rd_addr];
    end
  end

  // Pixel phase, raster counters, registered video outputs and frame pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_en       <= 1'b0;
      h_cnt        <= 10'd0;
      v_cnt        <= 10'd0;
      oVGA_R       <= 8'd0;
      oVGA_G       <= 8'd0;
      oVGA_B       <= 8'd0;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_N <= 1'b0;
      oFrameStart  <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      oFrameStart <= 1'b0;
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= 10'd0;
          v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
        oVGA_R       <= visible ? expand3(rd_data[8:6]) : 8'd0;
        oVGA_G       <= visible ? expand3(rd_data[5:3]) : 8'd0;
        oVGA_B       <= visible ? expand3(rd_data[2:0]) : 8'd0;
        oVGA_HS      <= hs_s;
        oVGA_VS      <= vs_s;
        oVGA_BLANK_N <= visible;
        oFrameStart  <= at_wrap;
      end
    end
  end

  // Out-of-range plot indication, one clock after the rejected strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      oWriteDropped <= 1'b0;
    end else begin
      oWriteDropped <= iPlot && !wr_ok;
    end
  end

  assign oVGA_SYNC_N = 1'b0;
  assign oVGA_CLK    = pix_en;

endmodule
